// File: rtl/gamepad_events.sv
// gamepad_events
//   Turns the 24-bit latched gamepad button vector into a queued stream of
//   discrete key events (press, auto-repeat and, optionally, release) for the
//   game FSM.
//   Bit map: [23:12] pad 0 = B,Y,Sel,Start,Up,Down,Left,Right,A,X,L,R
//            (bit 23 = B); [11:0] pad 1, same order.
//
// Ports
//   clk          in   1   system clock
//   rst          in   1   synchronous reset, active-high
//   buttons      in   24  latched button levels, 1 = pressed
//   evt_valid    out  1   event available at head of queue
//   evt_ready    in   1   consumer accepts head event
//   evt_code     out  5   button index 0..23 of head event
//   evt_repeat   out  1   head event is an auto-repeat
//   evt_release  out  1   head event is a release (0 when compiled out)
//
// Handshake: the head event is transferred on every clk edge where
//   evt_valid & evt_ready are both 1; evt_valid stays high and the head stays
//   stable until that transfer happens.
//
// Build option: define GAMEPAD_RELEASE_EVT_EN to also emit release events.
module gamepad_events #(
    parameter int          TICK_DIV     = 50000,
    parameter int          REPEAT_DELAY = 400,
    parameter int          REPEAT_RATE  = 100,
    parameter logic [23:0] REPEAT_MASK  = 24'h0F00F0,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] buttons,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [4:0]  evt_code,
    output logic        evt_repeat,
    output logic        evt_release
);

    localparam int TW   = $clog2(TICK_DIV);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMW  = $clog2(TMAX + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
`ifdef GAMEPAD_RELEASE_EVT_EN
    localparam int EW   = 7;   // {release, repeat, code}
`else
    localparam int EW   = 6;   // {repeat, code}
`endif

    typedef enum logic [1:0] {TRK_IDLE, TRK_DELAY, TRK_RATE} trk_state_t;

    function automatic logic [4:0] lowest(input logic [23:0] v);
        lowest = 5'd0;
        for (int i = 23; i >= 0; i--) begin
            if (v[i]) lowest = 5'(i);
        end
    endfunction

    // Edge detect and press-pending vector
    logic [23:0] prev, pending, press_clr, rise, rep_rise;
    logic [4:0]  press_idx, rep_idx;
    assign rise      = buttons & ~prev;
    assign rep_rise  = rise & REPEAT_MASK;
    assign press_idx = lowest(pending);
    assign rep_idx   = lowest(rep_rise);

`ifdef GAMEPAD_RELEASE_EVT_EN
    logic [23:0] rel_pend, rel_clr, fall;
    logic [4:0]  rel_idx;
    assign fall    = ~buttons & prev;
    assign rel_idx = lowest(rel_pend);
`endif

    // Tick prescaler
    logic [TW-1:0] tick_cnt;
    logic          tick;
    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    // Repeat tracker
    trk_state_t     trk_state, trk_state_nxt;
    logic [4:0]     trk_idx, trk_idx_nxt;
    logic [TMW-1:0] timer, timer_nxt;
    logic           rep_pend, rep_set, rep_kill, rep_pop;

    always_comb begin
        trk_state_nxt = trk_state;
        trk_idx_nxt   = trk_idx;
        timer_nxt     = timer;
        rep_set       = 1'b0;
        rep_kill      = 1'b0;
        if (rep_rise != '0) begin
            // A new repeatable press always takes over the tracker. Any
            // repeat still queued for the old button is stale, so drop it.
            trk_state_nxt = TRK_DELAY;
            trk_idx_nxt   = rep_idx;
            timer_nxt     = TMW'(REPEAT_DELAY);
            rep_kill      = 1'b1;
        end else if (trk_state != TRK_IDLE) begin
            if (!buttons[trk_idx]) begin
                trk_state_nxt = TRK_IDLE;
                rep_kill      = 1'b1;
            end else if (tick) begin
                if (timer <= TMW'(1)) begin
                    rep_set       = 1'b1;
                    trk_state_nxt = TRK_RATE;
                    timer_nxt     = TMW'(REPEAT_RATE);
                end else begin
                    timer_nxt = timer - TMW'(1);
                end
            end
        end
    end

    // Event queue
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [EW-1:0] head, push_data;
    logic          push, pop, can_push;

    assign head     = mem[rd_ptr];
    assign pop      = evt_valid & evt_ready;
    // A pop in the same cycle frees the slot, so a full queue may still push.
    assign can_push = (count != CW'(FIFO_DEPTH)) || pop;

    // Drain priority: press, then repeat, then release.
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        press_clr = '0;
        rep_pop   = 1'b0;
`ifdef GAMEPAD_RELEASE_EVT_EN
        rel_clr   = '0;
`endif
        if (can_push) begin
            if (pending != '0) begin
                push                = 1'b1;
                push_data[4:0]      = press_idx;
                press_clr[press_idx] = 1'b1;
            end else if (rep_pend) begin
                push           = 1'b1;
                push_data[5]   = 1'b1;
                push_data[4:0] = trk_idx;
                rep_pop        = 1'b1;
`ifdef GAMEPAD_RELEASE_EVT_EN
            end else if (rel_pend != '0) begin
                push             = 1'b1;
                push_data[6]     = 1'b1;
                push_data[4:0]   = rel_idx;
                rel_clr[rel_idx] = 1'b1;
`endif
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) trk_state <= TRK_IDLE;
        else     trk_state <= trk_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= buttons;   // buttons held through reset are not presses
            pending  <= '0;
            tick_cnt <= '0;
            trk_idx  <= 5'd0;
            timer    <= '0;
            rep_pend <= 1'b0;
`ifdef GAMEPAD_RELEASE_EVT_EN
            rel_pend <= '0;
`endif
        end else begin
            prev     <= buttons;
            // New edges win over a same-cycle drain of the same bit.
            pending  <= (pending & ~press_clr) | rise;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            trk_idx  <= trk_idx_nxt;
            timer    <= timer_nxt;
            if (rep_set)                  rep_pend <= 1'b1;
            else if (rep_kill || rep_pop) rep_pend <= 1'b0;
`ifdef GAMEPAD_RELEASE_EVT_EN
            rel_pend <= (rel_pend & ~rel_clr) | fall;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign evt_valid  = (count != '0);
    assign evt_code   = evt_valid ? head[4:0] : 5'd0;
    assign evt_repeat = evt_valid & head[5];
`ifdef GAMEPAD_RELEASE_EVT_EN
    assign evt_release = evt_valid & head[6];
`else
    assign evt_release = 1'b0;
`endif

endmodule
